// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage and IF/ID pipeline register for the 16-bit,
//   16-register pipeline. Fetches from a variable-latency instruction memory
//   over a request/valid handshake (one request outstanding at a time), keeps
//   a one-entry skid buffer so a word returning during a stall is never lost,
//   applies taken-branch redirects from ID and stops fetching on HLT.
//
// Ports
//   clk, rst        clock (rising edge) and asynchronous active-high reset
//   stall           from ID hazard unit: hold PC and IF/ID
//   branch_taken    ID-stage taken branch (ignored while stall=1)
//   branch_target   redirect address
//   imem_req        instruction memory request
//   imem_addr       request address, stable until imem_valid
//   imem_rdata      returned word, meaningful only with imem_valid
//   imem_valid      one-cycle response strobe (may coincide with req rising)
//   ifid_instr      IF/ID instruction
//   ifid_pc_plus2   IF/ID PC+2
//   ifid_valid      IF/ID holds a real instruction (0 = bubble)
//   halted          fetch stopped on HLT
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = 16'h0000,
    parameter logic [3:0]  HLT_OPC   = 4'hF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);

    // DROP: a redirect happened while a request was in flight; the stale
    // response must still be consumed before the new address can be issued.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DROP   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] req_addr;
    logic [15:0] buf_instr;
    logic        buf_valid;

    logic        br;
    logic        resp;
    logic        word_ready;
    logic [15:0] word;
    logic [15:0] pc_plus2;

    // A stalled ID instruction is frozen, so its branch decision is not final.
    assign br         = branch_taken & ~stall;
    assign imem_req   = ~rst & (state != HALTED) & ~buf_valid;
    assign imem_addr  = req_addr;
    assign halted     = (state == HALTED);

    assign resp       = imem_req & imem_valid;
    assign word_ready = buf_valid | resp;
    assign word       = buf_valid ? buf_instr : imem_rdata;
    assign pc_plus2   = pc + 16'd2;   // wraps modulo 2^16

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= FETCH;
            pc            <= RESET_PC;
            req_addr      <= RESET_PC;
            buf_valid     <= 1'b0;
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus2 <= 16'h0000;
            ifid_valid    <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (br) begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                        pc         <= branch_target;
                        buf_valid  <= 1'b0;
                        // An in-flight request must be drained on its old
                        // address; a same-cycle response is simply dropped.
                        if (imem_req && !imem_valid) state <= DROP;
                        else                         req_addr <= branch_target;
                    end else if (stall) begin
                        if (resp) buf_valid <= 1'b1;
                    end else if (word_ready) begin
                        ifid_instr    <= word;
                        ifid_pc_plus2 <= pc_plus2;
                        ifid_valid    <= 1'b1;
                        buf_valid     <= 1'b0;
                        if (word[15:12] == HLT_OPC) begin
                            state <= HALTED;
                        end else begin
                            pc       <= pc_plus2;
                            req_addr <= pc_plus2;
                        end
                    end else begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end
                end

                DROP: begin
                    if (br) pc <= branch_target;
                    if (!stall) begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                    end
                    if (resp) begin
                        // Stale word discarded; resume at the latest redirect.
                        req_addr <= br ? branch_target : pc;
                        state    <= FETCH;
                    end
                end

                HALTED: begin
                    // Only a redirect (wrong-path HLT) or reset leaves HALTED.
                    if (br) begin
                        ifid_instr <= NOP_INSTR;
                        ifid_valid <= 1'b0;
                        pc         <= branch_target;
                        req_addr   <= branch_target;
                        state      <= FETCH;
                    end
                end

                default: state <= FETCH;
            endcase
        end
    end

    // NOTE: the skid payload has no reset; it is only ever read while
    // buf_valid is set, and buf_valid itself is reset.
    always_ff @(posedge clk) begin
        if (state == FETCH && !br && stall && resp) buf_instr <= imem_rdata;
    end

endmodule
